controle_jogada_param: RTL
==========================

Name: controle_jogada_param

Overview:
Parametrised move-capture unit for the tic-tac-toe game datapath. It replaces ad-hoc button handling with a single FSM that:
- waits for all buttons to be released,
- filters a press for HOLD_CICLOS cycles,
- checks it for one-hot and against an occupancy mask,
- hands the encoded cell index to the main controller with a one-cycle pulse.

It generalises the fixed 9-button macro/micro selection to N_BOTOES cells. The main FSM instantiates it once and reuses it for both macro and micro moves.

Parameters:
N_BOTOES, 9, number of buttons/cells (2..32)
W_IDX, 4, width of encoded index; 2**W_IDX >= N_BOTOES
HOLD_CICLOS, 2, consecutive equal samples required to accept a press (>=1)
TIMEOUT_CICLOS, 1000, move timeout in cycles (used only with JOGADA_TIMEOUT_EN)

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
pedir  in  1  level; main FSM requests a move while high
botoes  in  N_BOTOES  raw button levels, already synchronised
ocupado  in  N_BOTOES  1 = cell unavailable
jogada  out  W_IDX  0-based index of accepted button; held until next accept
jogada_valida  out  1  one-cycle pulse: move accepted
jogada_invalida  out  1  one-cycle pulse: move rejected
aguardando  out  1  high in ESPERA/FILTRA
leds  out  N_BOTOES  ~ocupado while aguardando, else 0 (combinational)
timeout  out  1  one-cycle pulse on timeout (0 without feature)
db_estado  out  3  current state code

Behaviour:
- Reset: state OCIOSO; jogada=0, all pulses 0, aguardando=0, leds=0, counters 0. A reset mid-operation aborts the move; no pulse is emitted.
- States and codes: OCIOSO=0, ESPERA_LIBERA=1, ESPERA=2, FILTRA=3, AVALIA=4, VALIDA=5, INVALIDA=6, TIMEOUT=7.
- OCIOSO: pedir=1 -> ESPERA_LIBERA.
- ESPERA_LIBERA: botoes==0 -> ESPERA. A button held from the previous move is never accepted.
- ESPERA: botoes!=0 -> latch amostra=botoes, cnt=1, go to FILTRA. If HOLD_CICLOS==1, go straight to AVALIA.
- FILTRA:
  - botoes!=amostra -> ESPERA, cnt cleared.
  - Otherwise cnt++; when cnt reaches HOLD_CICLOS -> AVALIA.
- AVALIA:
  - amostra not one-hot -> INVALIDA.
  - (amostra & ocupado)!=0 -> INVALIDA.
  - Otherwise -> VALIDA, jogada<=index of set bit.
- VALIDA: jogada_valida=1 for this cycle only -> OCIOSO.
- INVALIDA: jogada_invalida=1 for this cycle only -> ESPERA_LIBERA. The player must release before retrying.
- Latency: first sampling edge e0, press stable -> jogada_valida high in the cycle after edge e0+HOLD_CICLOS.
- Cancel: pedir=0 in states 1-4 -> OCIOSO next edge, no pulse. VALIDA, INVALIDA and TIMEOUT always complete their single cycle.
- Priority per edge: reset > cancel > timeout > normal transition.
- jogada is updated only on entry to VALIDA.
- ocupado is sampled in AVALIA only; changes during filtering are tolerated.

Optional Feature:
Macro JOGADA_TIMEOUT_EN.
- Defined:
  - A counter of width ceil(log2(TIMEOUT_CICLOS+1)) clears on the OCIOSO->ESPERA_LIBERA transition.
  - It increments every cycle in states 1-4 and 6; invalid attempts do not clear it.
  - When it reaches TIMEOUT_CICLOS -> TIMEOUT: timeout=1 for one cycle -> OCIOSO.
  - Timeout wins over a simultaneous AVALIA result.
- Undefined: no counter, timeout tied 0, state 7 unreachable, TIMEOUT_CICLOS ignored.

Test Plan:
1. Reset, pedir=1, botoes=9'b000001000 for 2 cycles, ocupado=0 -> jogada_valida pulse 1 cycle, jogada=3, db_estado returns to 0.
2. pedir=1 with botoes=9'b000010000 already held -> stays in state 1, no pulse; release then press bit 4 for 2 cycles -> jogada=4 valid.
3. botoes=9'b000011000 for 2 cycles -> jogada_invalida pulse, jogada unchanged; botoes=bit 2 with ocupado[2]=1 -> jogada_invalida.
4. Press bit 1 for 1 cycle only (HOLD_CICLOS=2), or a press that changes bit mid-filter -> no pulse, state back to 2; leds=~ocupado while waiting.
5. Drop pedir during FILTRA -> OCIOSO next edge, no pulse. Assert reset during FILTRA -> all outputs 0.
6. JOGADA_TIMEOUT_EN, TIMEOUT_CICLOS=20: pedir=1, no press -> timeout pulse 20 cycles after entering state 1, then OCIOSO. N_BOTOES=16, W_IDX=4: bit 15 -> jogada=15.

Source files
------------

// File: rtl/controle_jogada_param.sv
// Move-capture unit: waits for release, debounces a press, validates it against the occupancy mask.
// Optional move timeout is enabled by defining JOGADA_TIMEOUT_EN.
module controle_jogada_param #(
  parameter int N_BOTOES       = 9,
  parameter int W_IDX          = 4,
  parameter int HOLD_CICLOS    = 2,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pedir,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] ocupado,
  output logic [W_IDX-1:0]    jogada,
  output logic                jogada_valida,
  output logic                jogada_invalida,
  output logic                aguardando,
  output logic [N_BOTOES-1:0] leds,
  output logic                timeout,
  output logic [2:0]          db_estado
);

  localparam int W_CNT = (HOLD_CICLOS < 2) ? 1 : $clog2(HOLD_CICLOS + 1);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    ESPERA_LIBERA = 3'd1,
    ESPERA        = 3'd2,
    FILTRA        = 3'd3,
    AVALIA        = 3'd4,
    VALIDA        = 3'd5,
    INVALIDA      = 3'd6,
    TIMEOUT       = 3'd7
  } estado_t;

  estado_t             estado, prox;
  logic [N_BOTOES-1:0] amostra, amostra_prox;
  logic [W_CNT-1:0]    cnt, cnt_prox;
  logic [W_IDX-1:0]    jogada_prox, indice;
  logic                um_quente, conflito, cancela, estoura;

  // Index of the highest set bit; only meaningful when the sample is one-hot.
  always_comb begin
    indice = '0;
    for (int i = 0; i < N_BOTOES; i++)
      if (amostra[i]) indice = W_IDX'(i);
  end

  assign um_quente = (amostra != '0) && ((amostra & (amostra - N_BOTOES'(1))) == '0);
  assign conflito  = |(amostra & ocupado);
  assign cancela   = !pedir && (estado inside {ESPERA_LIBERA, ESPERA, FILTRA, AVALIA});

`ifdef JOGADA_TIMEOUT_EN
  localparam int W_TMO = $clog2(TIMEOUT_CICLOS + 1);
  logic [W_TMO-1:0] tmo_cnt;
  logic             conta;

  // Invalid attempts keep counting: the budget covers the whole move request.
  assign conta   = estado inside {ESPERA_LIBERA, ESPERA, FILTRA, AVALIA, INVALIDA};
  assign estoura = conta && (tmo_cnt == W_TMO'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge clock) begin
    if (reset)                        tmo_cnt <= '0;
    else if (estado == OCIOSO && pedir) tmo_cnt <= '0;
    else if (conta)                   tmo_cnt <= tmo_cnt + W_TMO'(1);
  end

  assign timeout = (estado == TIMEOUT);
`else
  assign estoura = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    prox         = estado;
    amostra_prox = amostra;
    cnt_prox     = cnt;
    jogada_prox  = jogada;
    if (cancela) begin
      prox     = OCIOSO;
      cnt_prox = '0;
    end else if (estoura) begin
      prox     = TIMEOUT;
      cnt_prox = '0;
    end else begin
      case (estado)
        OCIOSO:        if (pedir) prox = ESPERA_LIBERA;
        ESPERA_LIBERA: if (botoes == '0) prox = ESPERA;
        ESPERA: begin
          if (botoes != '0) begin
            amostra_prox = botoes;
            cnt_prox     = W_CNT'(1);
            prox         = (HOLD_CICLOS == 1) ? AVALIA : FILTRA;
          end
        end
        FILTRA: begin
          if (botoes != amostra) begin
            prox     = ESPERA;
            cnt_prox = '0;
          end else begin
            cnt_prox = cnt + W_CNT'(1);
            if (cnt_prox == W_CNT'(HOLD_CICLOS)) prox = AVALIA;
          end
        end
        AVALIA: begin
          if (!um_quente || conflito) begin
            prox = INVALIDA;
          end else begin
            prox        = VALIDA;
            jogada_prox = indice;
          end
        end
        VALIDA:   prox = OCIOSO;
        INVALIDA: prox = ESPERA_LIBERA;
        default:  prox = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= OCIOSO;
      amostra <= '0;
      cnt     <= '0;
      jogada  <= '0;
    end else begin
      estado  <= prox;
      amostra <= amostra_prox;
      cnt     <= cnt_prox;
      jogada  <= jogada_prox;
    end
  end

  assign jogada_valida   = (estado == VALIDA);
  assign jogada_invalida = (estado == INVALIDA);
  assign aguardando      = (estado == ESPERA) || (estado == FILTRA);
  assign leds            = aguardando ? ~ocupado : '0;
  assign db_estado       = estado;

endmodule
